decode_issue: RTL and testbench

Decode/issue stage of the pipelined MIPS core, between the IF/ID register and the EX stage. Drives the register file read addresses from the fetched instruction, merges same-cycle writeback data into the operands, and detects load-use hazards, stalling fetch for one cycle. Holds the ID/EX pipeline register with bubble insertion and branch flush, plus a saturating hazard-stall counter.

---
 rtl/decode_issue.sv | 148 ++++++++++++++
 tb/tb_decode_issue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode/issue stage: register-file addressing, writeback bypass, load-use stall
// detection, and the ID/EX pipeline register with bubble and flush handling.
module decode_issue #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         if_valid,
    input  logic [31:0]  if_instr,
    input  logic [W-1:0] if_pc4,
    output logic [4:0]   rf_addr1,
    output logic [4:0]   rf_addr2,
    input  logic [W-1:0] rf_read1,
    input  logic [W-1:0] rf_read2,
    input  logic         wb_write,
    input  logic [4:0]   wb_reg,
    input  logic [W-1:0] wb_data,
    input  logic         flush,
    output logic         stall,
    output logic         ex_valid,
    output logic [W-1:0] ex_a,
    output logic [W-1:0] ex_b,
    output logic [W-1:0] ex_imm,
    output logic [4:0]   ex_rs,
    output logic [4:0]   ex_rt,
    output logic [4:0]   ex_rd,
    output logic [5:0]   ex_opcode,
    output logic [5:0]   ex_funct,
    output logic         ex_memread,
    output logic         ex_regwrite,
    output logic [W-1:0] ex_pc4,
    output logic [15:0]  hz_count
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [5:0]   opcode;
        logic [5:0]   funct;
        logic         memread;
        logic         regwrite;
        logic [W-1:0] pc4;
    } idex_t;

    idex_t       idex_q, idex_d;
    logic [15:0] hz_count_q, hz_count_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, dest;
    logic       dec_regwrite, dec_memread, rt_is_src, hz;

    assign opcode   = if_instr[31:26];
    assign rs       = if_instr[25:21];
    assign rt       = if_instr[20:16];
    assign rd       = if_instr[15:11];
    assign rf_addr1 = rs;
    assign rf_addr2 = rt;

    // Non-writing opcodes resolve to destination 0 so the load-use check ignores them.
    always_comb begin
        dest        = 5'd0;
        dec_memread = 1'b0;
        rt_is_src   = 1'b0;
        case (opcode)
            OpRType: begin
                dest      = rd;
                rt_is_src = 1'b1;
            end
            OpLw: begin
                dest        = rt;
                dec_memread = 1'b1;
            end
            OpSw, OpBeq, OpBne:            rt_is_src = 1'b1;
            OpAddi, OpSlti, OpAndi, OpOri: dest = rt;
            default: ;
        endcase
        dec_regwrite = (dest != 5'd0);
    end

    assign hz = if_valid & idex_q.valid & idex_q.memread & (idex_q.rd != 5'd0) &
                ((idex_q.rd == rs) | (rt_is_src & (idex_q.rd == rt)));
    assign stall = hz & ~flush & ~reset;

    always_comb begin
        idex_d = '0;
        if (if_valid && !flush && !hz) begin
            idex_d.valid    = 1'b1;
            idex_d.a        = (wb_write && wb_reg != 5'd0 && wb_reg == rs) ? wb_data : rf_read1;
            idex_d.b        = (wb_write && wb_reg != 5'd0 && wb_reg == rt) ? wb_data : rf_read2;
            idex_d.imm      = {{(W - 16){if_instr[15]}}, if_instr[15:0]};
            idex_d.rs       = rs;
            idex_d.rt       = rt;
            idex_d.rd       = dest;
            idex_d.opcode   = opcode;
            idex_d.funct    = if_instr[5:0];
            idex_d.memread  = dec_memread;
            idex_d.regwrite = dec_regwrite;
            idex_d.pc4      = if_pc4;
        end
    end

    always_comb begin
        hz_count_d = hz_count_q;
        if (stall && hz_count_q != 16'hFFFF) begin
            hz_count_d = hz_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q     <= '0;
            hz_count_q <= 16'd0;
        end else begin
            idex_q     <= idex_d;
            hz_count_q <= hz_count_d;
        end
    end

    assign ex_valid    = idex_q.valid;
    assign ex_a        = idex_q.a;
    assign ex_b        = idex_q.b;
    assign ex_imm      = idex_q.imm;
    assign ex_rs       = idex_q.rs;
    assign ex_rt       = idex_q.rt;
    assign ex_rd       = idex_q.rd;
    assign ex_opcode   = idex_q.opcode;
    assign ex_funct    = idex_q.funct;
    assign ex_memread  = idex_q.memread;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_pc4      = idex_q.pc4;
    assign hz_count    = hz_count_q;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed vector table, hand-written
// reset/saturation sequences and random stimulus against a behavioural model.
module tb_decode_issue;

    logic        clock = 1'b0;
    logic        reset, if_valid, wb_write, flush;
    logic [31:0] if_instr, if_pc4, rf_read1, rf_read2, wb_data;
    logic [4:0]  wb_reg, rf_addr1, rf_addr2;
    logic        stall, ex_valid, ex_memread, ex_regwrite;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_opcode, ex_funct;
    logic [15:0] hz_count;

    always #5 clock = ~clock;

    decode_issue #(.W(32)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc4(if_pc4), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_read1(rf_read1),
        .rf_read2(rf_read2), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct(ex_funct), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_pc4(ex_pc4), .hz_count(hz_count)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op, fn;
        logic        mr, rw;
        logic [31:0] pc4;
    } ex_t;

    typedef struct {
        logic [31:0] instr;
        logic        vld, fl;
        logic [31:0] r1, r2;
        logic        wbw;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        e_st, e_v;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_rd;
        logic        e_rw, e_mr;
        logic [15:0] e_hz;
    } vec_t;

    localparam logic [31:0] Add0  = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] Lw    = 32'h8C220004;  // lw $2,4($1)
    localparam logic [31:0] Add   = 32'h00441820;  // add $3,$2,$4
    localparam logic [31:0] Sw    = 32'hAC450000;  // sw $5,0($2)
    localparam logic [31:0] Addi  = 32'h20460001;  // addi $6,$2,1
    localparam logic [31:0] Addi2 = 32'h20020001;  // addi $2,$0,1

    int   n_chk = 0;
    int   n_fail = 0;
    ex_t  m_ex = '0;
    int   m_hz = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ex_t dut_ex();
        return {ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct,
                ex_memread, ex_regwrite, ex_pc4};
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    endfunction

    // What an issued instruction should look like in EX.
    function automatic ex_t model_issue(input logic [31:0] instr, pc4, r1, r2,
                                        input logic wbw, input logic [4:0] wbreg,
                                        input logic [31:0] wbdata);
        ex_t e;
        logic [5:0] op;
        op       = instr[31:26];
        e        = '0;
        e.valid  = 1'b1;
        e.rs     = instr[25:21];
        e.rt     = instr[20:16];
        e.op     = op;
        e.fn     = instr[5:0];
        e.imm    = 32'($signed(instr[15:0]));
        e.pc4    = pc4;
        e.a      = (wbw && wbreg != 0 && wbreg == e.rs) ? wbdata : r1;
        e.b      = (wbw && wbreg != 0 && wbreg == e.rt) ? wbdata : r2;
        if (op == 6'h00) e.rd = instr[15:11];
        else if (op inside {6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D}) e.rd = instr[20:16];
        e.rw     = (e.rd != 0);
        e.mr     = (op == 6'h23);
        return e;
    endfunction

    task automatic step(input logic rst, vld, input logic [31:0] instr, pc4, r1, r2,
                        input logic wbw, input logic [4:0] wbreg, input logic [31:0] wbdata,
                        input logic fl, output logic st_o);
        logic hz, exp_st;
        @(negedge clock);
        reset = rst; if_valid = vld; if_instr = instr; if_pc4 = pc4;
        rf_read1 = r1; rf_read2 = r2; wb_write = wbw; wb_reg = wbreg; wb_data = wbdata;
        flush = fl;
        #2;
        st_o = stall;
        hz = vld && m_ex.valid && m_ex.mr && m_ex.rd != 0 &&
             (m_ex.rd == instr[25:21] || (reads_rt(instr[31:26]) && m_ex.rd == instr[20:16]));
        exp_st = hz && !fl && !rst;
        chk("stall", stall, exp_st);
        chk("rf_addr", {rf_addr1, rf_addr2}, {instr[25:21], instr[20:16]});
        if (rst) begin
            m_ex = '0;
            m_hz = 0;
        end else begin
            if (exp_st && m_hz < 65535) m_hz++;
            m_ex = (vld && !fl && !hz) ? model_issue(instr, pc4, r1, r2, wbw, wbreg, wbdata)
                                      : '0;
        end
        @(posedge clock);
        #1;
        chk("ex_regs", dut_ex(), m_ex);
        chk("hz_count", hz_count, m_hz[15:0]);
    endtask

    initial begin
        logic st;
        vec_t v;

        // Directed vectors: each row is one cycle, expectations hand-derived.
        vq.push_back('{Add0, 1'b1, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 16'd0});
        vq.push_back('{Add0, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 5'd1, 32'hDEAD,
                       1'b0, 1'b1, 32'hDEAD, 32'd7, 5'd3, 1'b1, 1'b0, 16'd0});
        vq.push_back('{Add0, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 5'd0, 32'hDEAD,
                       1'b0, 1'b1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 16'd0});
        vq.push_back('{Lw, 1'b1, 1'b0, 32'd100, 32'd9, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd100, 32'd9, 5'd2, 1'b1, 1'b1, 16'd0});
        vq.push_back('{Add, 1'b1, 1'b0, 32'd11, 32'd12, 1'b0, 5'd0, 32'h0,
                       1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd1});
        vq.push_back('{Add, 1'b1, 1'b0, 32'd11, 32'd12, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd11, 32'd12, 5'd3, 1'b1, 1'b0, 16'd1});
        vq.push_back('{Lw, 1'b1, 1'b0, 32'd100, 32'd9, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd100, 32'd9, 5'd2, 1'b1, 1'b1, 16'd1});
        vq.push_back('{Sw, 1'b1, 1'b0, 32'd20, 32'd21, 1'b0, 5'd0, 32'h0,
                       1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd2});
        vq.push_back('{Sw, 1'b1, 1'b0, 32'd20, 32'd21, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd20, 32'd21, 5'd0, 1'b0, 1'b0, 16'd2});
        vq.push_back('{Lw, 1'b1, 1'b0, 32'd100, 32'd9, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd100, 32'd9, 5'd2, 1'b1, 1'b1, 16'd2});
        vq.push_back('{Addi, 1'b1, 1'b0, 32'd30, 32'd31, 1'b0, 5'd0, 32'h0,
                       1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd3});
        vq.push_back('{Addi, 1'b1, 1'b0, 32'd30, 32'd31, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd30, 32'd31, 5'd6, 1'b1, 1'b0, 16'd3});
        vq.push_back('{Lw, 1'b1, 1'b0, 32'd100, 32'd9, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd100, 32'd9, 5'd2, 1'b1, 1'b1, 16'd3});
        vq.push_back('{Addi2, 1'b1, 1'b0, 32'd0, 32'd40, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd0, 32'd40, 5'd2, 1'b1, 1'b0, 16'd3});
        vq.push_back('{Lw, 1'b1, 1'b0, 32'd100, 32'd9, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd100, 32'd9, 5'd2, 1'b1, 1'b1, 16'd3});
        vq.push_back('{Add, 1'b1, 1'b1, 32'd11, 32'd12, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd3});
        vq.push_back('{Add, 1'b1, 1'b0, 32'd11, 32'd12, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd11, 32'd12, 5'd3, 1'b1, 1'b0, 16'd3});
        vq.push_back('{32'h0, 1'b1, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b1, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0, 16'd3});
        vq.push_back('{Add, 1'b0, 1'b0, 32'd11, 32'd12, 1'b0, 5'd0, 32'h0,
                       1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd3});

        // Reset held two cycles with a load presented.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, Lw, 32'h4, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0, 1'b0, st);
            chk("reset_stall", st, 1'b0);
        end
        chk("reset_ex", dut_ex(), '0);
        chk("reset_hz", hz_count, 16'd0);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            step(1'b0, v.vld, v.instr, 32'h400 + 32'(i * 4), v.r1, v.r2, v.wbw, v.wbreg,
                 v.wbdata, v.fl, st);
            chk($sformatf("vec%0d_stall", i), st, v.e_st);
            chk($sformatf("vec%0d_ex", i),
                {ex_valid, ex_a, ex_b, ex_rd, ex_regwrite, ex_memread, hz_count},
                {v.e_v, v.e_a, v.e_b, v.e_rd, v.e_rw, v.e_mr, v.e_hz});
        end

        // Reset arriving in a hazard cycle suppresses the stall and clears the counter.
        step(1'b0, 1'b1, Lw, 32'h500, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0, 1'b0, st);
        step(1'b1, 1'b1, Add, 32'h504, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0, 1'b0, st);
        chk("midreset_stall", st, 1'b0);
        chk("midreset_valid", ex_valid, 1'b0);
        chk("midreset_hz", hz_count, 16'd0);

        // Random traffic over a small register window so hazards and bypasses are common.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0]  ops [9];
            logic [5:0]  op;
            logic [31:0] instr;
            int          sel;
            ops   = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D};
            sel   = int'($urandom_range(0, 9));
            op    = (sel == 9) ? 6'($urandom) : ops[sel];
            instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 11'($urandom)};
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, instr, $urandom,
                 $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 7) == 0, st);
        end

        // Saturation: preload the counter near the top, then keep stalling.
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, st);
        force dut.hz_count_q = 16'hFFFD;
        m_hz = 65533;
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, st);
        release dut.hz_count_q;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, Lw, 32'h600, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0, 1'b0, st);
            step(1'b0, 1'b1, Add, 32'h604, 32'd3, 32'd4, 1'b0, 5'd0, 32'h0, 1'b0, st);
            chk("sat_stall", st, 1'b1);
            step(1'b0, 1'b1, Add, 32'h604, 32'd3, 32'd4, 1'b0, 5'd0, 32'h0, 1'b0, st);
        end
        chk("sat_hz", hz_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
